// File: rtl/filter_peak_scheduler_pkg.sv
// Shared settings for the filter-bank peak scheduler: default sizes,
// FSM state encoding and the stimulus mode type.
package filter_peak_scheduler_pkg;

  localparam int NUM_FILTERS_DEF      = 21;
  localparam int SETTLE_CYCLES_DEF    = 64;
  localparam int SIZE_WINDOW_DEF      = 16;
  localparam int SIZE_DELAY_DEF       = 4;
  localparam int SIZE_FILTER_DATA_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    REPORT,
    DONE
  } sched_state_t;

  // {overlay, rate}
  typedef logic [1:0] stim_mode_t;

endpackage

// File: rtl/filter_peak_scheduler_peak_tracker.sv
// Running signed maximum of one filter output; clear reloads the
// most-negative value so the first enabled sample always wins.
module peak_tracker #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] peak
);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      peak_q <= MOST_NEG;
    end else if (enable && ($signed(data_in) > $signed(peak_q))) begin
      peak_q <= data_in;
    end
  end

  assign peak = peak_q;

endmodule

// File: rtl/filter_peak_scheduler.sv
// Sweeps the signal generator through all four stimulus modes, measures the
// signed peak of each enabled filter output and streams the results out.
module filter_peak_scheduler
  import filter_peak_scheduler_pkg::*;
#(
  parameter int NUM_FILTERS      = NUM_FILTERS_DEF,
  parameter int SETTLE_CYCLES    = SETTLE_CYCLES_DEF,
  parameter int SIZE_WINDOW      = SIZE_WINDOW_DEF,
  parameter int SIZE_DELAY       = SIZE_DELAY_DEF,
  parameter int SIZE_FILTER_DATA = SIZE_FILTER_DATA_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [SIZE_WINDOW-1:0]                window_len,
  input  logic [SIZE_DELAY-1:0]                 delay_cfg,
  input  logic [NUM_FILTERS-1:0]                chan_mask,
  input  logic [NUM_FILTERS*SIZE_FILTER_DATA-1:0] filter_data,
  output logic                                  test_overlay,
  output logic                                  test_rate,
  output logic [SIZE_DELAY-1:0]                 test_delay,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [1:0]                            res_mode,
  output logic [4:0]                            res_chan,
  output logic [SIZE_FILTER_DATA-1:0]           res_peak,
  output logic                                  busy,
  output logic                                  done
);

  localparam int CW = $clog2(NUM_FILTERS > 1 ? NUM_FILTERS : 2);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = SIZE_FILTER_DATA;

  sched_state_t state_q, state_d;
  stim_mode_t   mode_q, mode_d;
  logic [CW-1:0]          chan_q, chan_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [SIZE_WINDOW-1:0] win_cnt_q, win_cnt_d;
  logic [SIZE_WINDOW-1:0] win_len_q, win_len_d;
  logic [NUM_FILTERS-1:0] mask_q, mask_d;
  logic [SIZE_DELAY-1:0]  delay_q, delay_d;

  logic                  test_overlay_q, test_overlay_d;
  logic                  test_rate_q, test_rate_d;
  logic [SIZE_DELAY-1:0] test_delay_q, test_delay_d;
  logic                  res_valid_q, res_valid_d;
  logic [1:0]            res_mode_q, res_mode_d;
  logic [4:0]            res_chan_q, res_chan_d;
  logic [DW-1:0]         res_peak_q, res_peak_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic          clear_peaks, measure_en, advance, stim_active;
  logic [DW-1:0] sel_peak, sel_sample;
  logic [DW-1:0] peak_q [NUM_FILTERS];

  for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_track
    peak_tracker #(.W(DW)) u_track (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear_peaks),
      .enable  (measure_en),
      .data_in (filter_data[g*DW +: DW]),
      .peak    (peak_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      mode_q         <= '0;
      chan_q         <= '0;
      settle_q       <= '0;
      win_cnt_q      <= '0;
      win_len_q      <= '0;
      mask_q         <= '0;
      delay_q        <= '0;
      test_overlay_q <= 1'b0;
      test_rate_q    <= 1'b0;
      test_delay_q   <= '0;
      res_valid_q    <= 1'b0;
      res_mode_q     <= '0;
      res_chan_q     <= '0;
      res_peak_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      chan_q         <= chan_d;
      settle_q       <= settle_d;
      win_cnt_q      <= win_cnt_d;
      win_len_q      <= win_len_d;
      mask_q         <= mask_d;
      delay_q        <= delay_d;
      test_overlay_q <= test_overlay_d;
      test_rate_q    <= test_rate_d;
      test_delay_q   <= test_delay_d;
      res_valid_q    <= res_valid_d;
      res_mode_q     <= res_mode_d;
      res_chan_q     <= res_chan_d;
      res_peak_q     <= res_peak_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    chan_d      = chan_q;
    settle_d    = settle_q;
    win_cnt_d   = win_cnt_q;
    win_len_d   = win_len_q;
    mask_d      = mask_q;
    delay_d     = delay_q;
    clear_peaks = 1'b0;
    measure_en  = (state_q == MEASURE);
    advance     = !mask_q[chan_q] || (res_valid_q && res_ready);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          delay_d   = delay_cfg;
          mask_d    = chan_mask;
          win_len_d = (window_len == '0) ? SIZE_WINDOW'(1) : window_len;
          mode_d    = '0;
          settle_d  = '0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d     = MEASURE;
          win_cnt_d   = '0;
          clear_peaks = 1'b1;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      MEASURE: begin
        if (win_cnt_q == win_len_q - SIZE_WINDOW'(1)) begin
          state_d = REPORT;
          chan_d  = '0;
        end else begin
          win_cnt_d = win_cnt_q + SIZE_WINDOW'(1);
        end
      end
      REPORT: begin
        if (advance) begin
          if (chan_q == CW'(NUM_FILTERS - 1)) begin
            if (mode_q == 2'd3) begin
              state_d = DONE;
            end else begin
              mode_d   = mode_q + 2'd1;
              settle_d = '0;
              state_d  = SETTLE;
            end
          end else begin
            chan_d = chan_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values; on the MEASURE->REPORT
  // edge the tracker has not yet absorbed the final sample, so fold it in.
  always_comb begin
    sel_peak    = peak_q[chan_d];
    sel_sample  = filter_data[32'(chan_d) * DW +: DW];
    stim_active = (state_d == SETTLE) || (state_d == MEASURE) || (state_d == REPORT);

    test_overlay_d = stim_active ? mode_d[1] : 1'b0;
    test_rate_d    = stim_active ? mode_d[0] : 1'b0;
    test_delay_d   = stim_active ? delay_d : '0;
    res_valid_d    = (state_d == REPORT) && mask_q[chan_d];
    res_mode_d     = (state_d == REPORT) ? mode_d : 2'd0;
    res_chan_d     = (state_d == REPORT) ? 5'(chan_d) : 5'd0;
    res_peak_d     = sel_peak;
    if ((state_q == MEASURE) && ($signed(sel_sample) > $signed(sel_peak))) begin
      res_peak_d = sel_sample;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign test_overlay = test_overlay_q;
  assign test_rate    = test_rate_q;
  assign test_delay   = test_delay_q;
  assign res_valid    = res_valid_q;
  assign res_mode     = res_mode_q;
  assign res_chan     = res_chan_q;
  assign res_peak     = res_peak_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_filter_peak_scheduler.sv
// Directed sweeps of filter_peak_scheduler with a result scoreboard drained
// by an independent handshake monitor.
module tb_filter_peak_scheduler;

  localparam int NF  = 21;
  localparam int DW  = 16;
  localparam int DLW = 4;
  localparam int WW  = 16;
  localparam int SC  = 64;

  logic                clk;
  logic                reset;
  logic                start;
  logic [WW-1:0]       window_len;
  logic [DLW-1:0]      delay_cfg;
  logic [NF-1:0]       chan_mask;
  logic [NF*DW-1:0]    filter_data;
  logic                test_overlay;
  logic                test_rate;
  logic [DLW-1:0]      test_delay;
  logic                res_valid;
  logic                res_ready;
  logic [1:0]          res_mode;
  logic [4:0]          res_chan;
  logic [DW-1:0]       res_peak;
  logic                busy;
  logic                done;

  typedef struct {
    int mode;
    int chan;
    int peak;
  } exp_t;

  exp_t sbQ[$];
  int   total = 0;
  int   bad = 0;
  int   doneCount = 0;
  int   handshakes = 0;
  logic signed [DW-1:0] seq2 [4];

  logic          holdPending = 1'b0;
  logic [1:0]    holdMode;
  logic [4:0]    holdChan;
  logic [DW-1:0] holdPeak;

  filter_peak_scheduler #(
    .NUM_FILTERS      (NF),
    .SETTLE_CYCLES    (SC),
    .SIZE_WINDOW      (WW),
    .SIZE_DELAY       (DLW),
    .SIZE_FILTER_DATA (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .window_len   (window_len),
    .delay_cfg    (delay_cfg),
    .chan_mask    (chan_mask),
    .filter_data  (filter_data),
    .test_overlay (test_overlay),
    .test_rate    (test_rate),
    .test_delay   (test_delay),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_mode     (res_mode),
    .res_chan     (res_chan),
    .res_peak     (res_peak),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] sampleVal(input int c, input int k);
    if (c == 2) return seq2[k];
    return DW'(c * 10 - 50 + k);
  endfunction

  // Handshake monitor: pops the scoreboard on every accepted result and
  // checks that an unaccepted result is held unchanged.
  always @(negedge clk) begin
    if (reset) begin
      sbQ.delete();
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        checkOutput("holdValid", int'(res_valid), 1);
        checkOutput("holdMode", int'(res_mode), int'(holdMode));
        checkOutput("holdChan", int'(res_chan), int'(holdChan));
        checkOutput("holdPeak", int'($signed(res_peak)), int'($signed(holdPeak)));
      end
      if (res_valid && res_ready) begin
        handshakes++;
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedResultChan", int'(res_chan), -1);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("resMode", int'(res_mode), e.mode);
          checkOutput("resChan", int'(res_chan), e.chan);
          checkOutput("resPeak", int'($signed(res_peak)), e.peak);
        end
      end
      holdPending = res_valid && !res_ready;
      holdMode    = res_mode;
      holdChan    = res_chan;
      holdPeak    = res_peak;
      if (done) doneCount++;
    end
  end

  // Drives the samples seen at edge n after start: sweep samples inside each
  // MEASURE window, max-positive junk everywhere else.
  task automatic driveData(input int n, input int p, input int w);
    int  ph;
    bit  meas;
    ph   = 0;
    meas = 1'b0;
    if (n >= SC + 1 && (n - SC - 1) < 4 * p) begin
      ph   = (n - SC - 1) % p;
      meas = (ph < w);
    end
    for (int c = 0; c < NF; c++) begin
      filter_data[c*DW +: DW] = meas ? sampleVal(c, ph) : 16'sh7fff;
    end
  endtask

  task automatic applyStimulus(input logic [NF-1:0] mask, input logic [WW-1:0] win,
                               input logic [DLW-1:0] dly, input int exp2, input bit pulseStart);
    int w, p, doneBefore;
    w = (win == 0) ? 1 : int'(win);
    p = SC + w + NF;
    for (int m = 0; m < 4; m++) begin
      for (int c = 0; c < NF; c++) begin
        if (mask[c]) sbQ.push_back('{m, c, (c == 2) ? exp2 : int'(sampleVal(c, w - 1))});
      end
    end
    doneBefore = doneCount;
    checkOutput("idleBusy", int'(busy), 0);
    checkOutput("idleDelay", int'(test_delay), 0);
    res_ready  = 1'b1;
    start      = 1'b1;
    window_len = win;
    chan_mask  = mask;
    delay_cfg  = dly;
    driveData(0, p, w);
    @(posedge clk); #1;
    start      = 1'b0;
    window_len = 16'd9;
    chan_mask  = '1;
    delay_cfg  = ~dly;
    checkOutput("startBusy", int'(busy), 1);
    for (int n = 1; n <= 4 * p + 2; n++) begin
      driveData(n, p, w);
      start = pulseStart && (n == SC + 2 || n == 4 * p + 1);
      @(posedge clk); #1;
      if (n % p == 1 && n < 4 * p) begin
        checkOutput("stimOverlay", int'(test_overlay), (n / p) / 2);
        checkOutput("stimRate", int'(test_rate), (n / p) % 2);
        checkOutput("stimDelay", int'(test_delay), int'(dly));
      end
      if (n == SC + w - 1) checkOutput("validBeforeReport", int'(res_valid), 0);
      if (n == SC + w) checkOutput("validFirstReport", int'(res_valid), int'(mask[0]));
      if (n == 4 * p) begin
        checkOutput("donePulse", int'(done), 1);
        checkOutput("doneBusy", int'(busy), 1);
        checkOutput("doneOverlay", int'(test_overlay), 0);
        checkOutput("doneDelay", int'(test_delay), 0);
      end
      if (n == 4 * p + 1) begin
        checkOutput("afterDone", int'(done), 0);
        checkOutput("afterBusy", int'(busy), 0);
      end
      if (n == 4 * p + 2) checkOutput("noRestartBusy", int'(busy), 0);
    end
    start = 1'b0;
    checkOutput("doneCount", doneCount - doneBefore, 1);
    checkOutput("sbEmpty", sbQ.size(), 0);
  endtask

  initial begin
    int hsBefore, doneBefore, waited;
    reset       = 1'b1;
    start       = 1'b0;
    res_ready   = 1'b1;
    window_len  = '0;
    delay_cfg   = '0;
    chan_mask   = '0;
    filter_data = '0;
    seq2        = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstValid", int'(res_valid), 0);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstDelay", int'(test_delay), 0);
    checkOutput("rstOverlay", int'(test_overlay), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] sweep: channel 0 only");
    applyStimulus(21'h1, 16'd4, 4'd5, 0, 1'b0);

    $display("[TB] sweep: channel 2 mixed samples");
    seq2 = '{-16'sd5, 16'sd7, -16'sd100, 16'sd3};
    applyStimulus(21'h4, 16'd4, 4'd6, 7, 1'b0);

    $display("[TB] sweep: channel 2 all negative, stray starts");
    seq2 = '{-16'sd9, -16'sd3, -16'sd4, -16'sd8};
    applyStimulus(21'h4, 16'd4, 4'd7, -3, 1'b1);

    $display("[TB] sweep: zero window");
    seq2 = '{-16'sd77, 16'sd0, 16'sd0, 16'sd0};
    applyStimulus(21'h4, 16'd0, 4'd3, -77, 1'b0);

    $display("[TB] sweep: toggling ready");
    for (int c = 0; c < NF; c++) filter_data[c*DW +: DW] = DW'(c * 10 - 50);
    for (int m = 0; m < 4; m++) begin
      sbQ.push_back('{m, 0, -50});
      sbQ.push_back('{m, 2, -30});
    end
    hsBefore   = handshakes;
    doneBefore = doneCount;
    start      = 1'b1;
    window_len = 16'd4;
    chan_mask  = 21'h5;
    delay_cfg  = 4'd2;
    @(posedge clk); #1;
    start  = 1'b0;
    waited = 0;
    while (doneCount == doneBefore && waited < 3000) begin
      res_ready = ~res_ready;
      @(posedge clk); #1;
      waited++;
    end
    res_ready = 1'b1;
    checkOutput("toggleTimeout", int'(waited < 3000), 1);
    checkOutput("toggleHandshakes", handshakes - hsBefore, 8);
    checkOutput("toggleSbEmpty", sbQ.size(), 0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset during report");
    res_ready  = 1'b0;
    start      = 1'b1;
    window_len = 16'd2;
    chan_mask  = 21'h1;
    delay_cfg  = 4'd4;
    @(posedge clk); #1;
    start  = 1'b0;
    waited = 0;
    while (!res_valid && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("reportValidSeen", int'(res_valid), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abortValid", int'(res_valid), 0);
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortDelay", int'(test_delay), 0);
    checkOutput("abortRate", int'(test_rate), 0);
    checkOutput("abortChan", int'(res_chan), 0);
    checkOutput("abortPeak", int'(res_peak), 0);
    reset     = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;

    $display("[TB] sweep: empty mask after reset");
    applyStimulus(21'h0, 16'd2, 4'd9, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter_peak_scheduler.md
Name: filter_peak_scheduler

Overview:
- Test-sequence controller for the filter bank.
- Drives the exponential signal generator's overlay/rate/delay controls through all four stimulus modes.
- For each mode: waits for the filter pipelines to settle, then captures the signed peak of every enabled filter output over a programmable window.
- Streams per-channel results out over a valid/ready interface; sits beside the generator and filter instances at top level.

Parameters:
- NUM_FILTERS, 21, number of filter outputs observed (v1..v21)
- SETTLE_CYCLES, 64, cycles to hold a new stimulus mode before measuring
- SIZE_WINDOW, 16, width of window_len

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- window_len  in  SIZE_WINDOW  measurement window length in cycles; 0 treated as 1
- delay_cfg  in  SIZE_DELAY  generator delay; latched on accepted start
- chan_mask  in  NUM_FILTERS  bit i=1 enables channel i; latched on accepted start
- filter_data  in  NUM_FILTERS*SIZE_FILTER_DATA  flattened filter outputs, channel i at bits [i*W +: W], signed
- test_overlay  out  1  generator overlay control
- test_rate  out  1  generator rate control
- test_delay  out  SIZE_DELAY  generator delay control
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_mode  out  2  stimulus mode of result, {overlay,rate}
- res_chan  out  5  channel index of result
- res_peak  out  SIZE_FILTER_DATA  signed peak value
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset: state=IDLE. All outputs 0: test_overlay, test_rate, test_delay, res_*, busy, done. Peak registers = most-negative value. Reset mid-sweep aborts immediately; no partial results are emitted.
- State IDLE: test_* outputs 0.
  - start=1 → next edge: latch delay_cfg, chan_mask, window_len (0→1); mode=0; settle counter=0; state=SETTLE.
  - test_overlay/test_rate/test_delay take the mode values on that same edge.
- State SETTLE: test_overlay=mode[1], test_rate=mode[0], test_delay=latched delay.
  - Counts exactly SETTLE_CYCLES cycles, then → MEASURE.
  - On entry to MEASURE, all peak registers load most-negative.
- State MEASURE: lasts exactly window_len cycles. Every cycle, each channel does peak_i = max_signed(peak_i, filter_data_i); the first MEASURE cycle's sample is included. Then → REPORT with chan=0.
- State REPORT: scans chan from 0 to NUM_FILTERS-1.
  - Masked channel: one cycle per channel with res_valid=0, then chan+1.
  - Enabled channel: res_valid=1 with res_mode=mode, res_chan=chan, res_peak=peak_chan. Held stable until res_ready=1.
  - Advances on the edge where valid&ready; res_valid may stay high back-to-back.
  - After the last channel (accepted or skipped): mode<3 → mode+1, → SETTLE; mode==3 → DONE.
  - chan_mask all-zero: REPORT emits nothing and just scans.
- State DONE: one cycle; done=1, test_* return to 0; → IDLE.
- busy=1 in SETTLE, MEASURE, REPORT, DONE.
- start while busy: ignored. start in the cycle DONE→IDLE: ignored; it is accepted from the next IDLE cycle.
- Inputs window_len, delay_cfg, chan_mask changed mid-sweep: no effect.
- Counters: settle counter and window counter sized so that they never wrap.
- Arithmetic: peaks are SIZE_FILTER_DATA-bit two's-complement compares; no extension, no saturation.
- Timing: no combinational path from res_ready to res_valid/res_* outputs; all outputs are registered.

Decomposition:
- Package package_settings adds:
  - NUM_FILTERS, SIZE_WINDOW, SETTLE_CYCLES defaults
  - typedef enum sched_state_t {IDLE, SETTLE, MEASURE, REPORT, DONE}
  - typedef logic [1:0] stim_mode_t
- One sub-module: peak_tracker (clk, reset, clear, enable, data_in, peak). Instantiated NUM_FILTERS times via generate.
- Main module holds the FSM, counters, stimulus outputs and the result mux.

Test Plan:
- reset held 3 cycles, then start=1, window_len=4, chan_mask=1, res_ready=1 → test_* change 1 cycle after start. First res_valid occurs after 1+64+4 cycles, res_mode=0, res_chan=0. Four results total, res_mode 0,1,2,3; done pulses once; busy falls with done.
- Channel 2 fed -5,7,-100,3 during MEASURE (window_len=4), chan_mask=0x4 → res_peak=7, res_chan=2. All-negative samples -9,-3,-4,-8 → res_peak=-3.
- chan_mask=0x00005 and res_ready toggled 0/1 every cycle → res_chan 0 then 2 per mode. Values stay stable while ready=0. Exactly 8 handshakes total.
- window_len=0 → MEASURE lasts 1 cycle; peak equals the single sample.
- reset asserted during REPORT with res_valid=1 → next cycle all outputs 0, state IDLE. Then start=1 with new delay_cfg → test_delay shows the new value.
- start pulsed during MEASURE and again in the DONE cycle → both ignored; only one sweep runs and done pulses exactly once.
